// File: rtl/ddr_wr_fifo_pkg.sv
// Shared widths, depths and threshold defaults for the 64-to-256 DDR write FIFO.
package ddr_wr_fifo_pkg;

  localparam int unsigned RATIO     = 4;
  localparam int unsigned LANE_BITS = 2;

  localparam int unsigned WR_DEPTH_WIDTH_DEF   = 11;
  localparam int unsigned WR_DATA_WIDTH_DEF    = 64;
  localparam int unsigned RD_DEPTH_WIDTH_DEF   = 9;
  localparam int unsigned RD_DATA_WIDTH_DEF    = RATIO * WR_DATA_WIDTH_DEF;
  localparam int unsigned ALMOST_FULL_NUM_DEF  = 2047;
  localparam int unsigned ALMOST_EMPTY_NUM_DEF = 80;

endpackage

// File: rtl/ddr_wr_fifo_ram.sv
// Simple dual-port RAM: lane-enabled narrow writes, full-width synchronous reads.
module ddr_wr_fifo_ram
  import ddr_wr_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RD_DEPTH_WIDTH_DEF,
  parameter int unsigned LANE_WIDTH = WR_DATA_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [RATIO-1:0]            wr_lane_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [LANE_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [RATIO*LANE_WIDTH-1:0] rd_data
);

  localparam int unsigned DataWidth = RATIO * LANE_WIDTH;
  localparam int unsigned Depth     = 2 ** ADDR_WIDTH;

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    for (int l = 0; l < RATIO; l++) begin
      if (wr_lane_en[l]) begin
        mem_q[wr_addr][l*LANE_WIDTH +: LANE_WIDTH] <= wr_data;
      end
    end
  end

  // Output register holds its value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/ddr_wr_fifo_64to256.sv
// Single-clock width-converting FIFO: 64-bit writes packed into 256-bit read words.
module ddr_wr_fifo_64to256
  import ddr_wr_fifo_pkg::*;
#(
  parameter int unsigned WR_DEPTH_WIDTH   = WR_DEPTH_WIDTH_DEF,
  parameter int unsigned WR_DATA_WIDTH    = WR_DATA_WIDTH_DEF,
  parameter int unsigned RD_DEPTH_WIDTH   = RD_DEPTH_WIDTH_DEF,
  parameter int unsigned RD_DATA_WIDTH    = RD_DATA_WIDTH_DEF,
  parameter int unsigned ALMOST_FULL_NUM  = ALMOST_FULL_NUM_DEF,
  parameter int unsigned ALMOST_EMPTY_NUM = ALMOST_EMPTY_NUM_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic [WR_DEPTH_WIDTH:0]  wr_water_level,
  output logic                     almost_full,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic [RD_DEPTH_WIDTH:0]  rd_water_level,
  output logic                     almost_empty
);

  localparam int unsigned WrPtrW = WR_DEPTH_WIDTH + 1;
  localparam int unsigned RdPtrW = RD_DEPTH_WIDTH + 1;
  localparam logic [WrPtrW-1:0] FullCount = WrPtrW'(1 << WR_DEPTH_WIDTH);
  localparam logic [WrPtrW-1:0] AfCount   = WrPtrW'(ALMOST_FULL_NUM);
  localparam logic [RdPtrW-1:0] AeCount   = RdPtrW'(ALMOST_EMPTY_NUM);

  logic [WrPtrW-1:0] wr_ptr_q, wr_ptr_d, count_d;
  logic [RdPtrW-1:0] rd_ptr_q, rd_ptr_d, rd_words_d;
  logic              wr_ok, rd_ok;
  logic [RATIO-1:0]  lane_en;

  // Acceptance uses the registered (pre-update) flags.
  assign wr_ok = wr_en & ~wr_full;
  assign rd_ok = rd_en & ~rd_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + WrPtrW'(wr_ok);
    rd_ptr_d   = rd_ptr_q + RdPtrW'(rd_ok);
    // Modular difference in write words; 2048 is distinguishable from 0 via the MSB.
    count_d    = wr_ptr_d - {rd_ptr_d, {LANE_BITS{1'b0}}};
    rd_words_d = count_d[WrPtrW-1:LANE_BITS];
    lane_en    = '0;
    if (wr_ok && !rst) begin
      lane_en[wr_ptr_q[LANE_BITS-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_full        <= 1'b0;
      almost_full    <= 1'b0;
      rd_empty       <= 1'b1;
      almost_empty   <= 1'b1;
      wr_water_level <= '0;
      rd_water_level <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_full        <= (count_d == FullCount);
      almost_full    <= (count_d >= AfCount);
      rd_empty       <= (rd_words_d == '0);
      almost_empty   <= (rd_words_d <= AeCount);
      wr_water_level <= count_d;
      rd_water_level <= rd_words_d;
    end
  end

  ddr_wr_fifo_ram #(
    .ADDR_WIDTH (RD_DEPTH_WIDTH),
    .LANE_WIDTH (WR_DATA_WIDTH)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .wr_lane_en (lane_en),
    .wr_addr    (wr_ptr_q[WR_DEPTH_WIDTH-1:LANE_BITS]),
    .wr_data    (wr_data),
    .rd_en      (rd_ok),
    .rd_addr    (rd_ptr_q[RD_DEPTH_WIDTH-1:0]),
    .rd_data    (rd_data)
  );

endmodule

// File: tb/tb_ddr_wr_fifo_64to256.sv
// Randomised scoreboard bench for the 64-to-256 write FIFO against a queue-based model.
module tb_ddr_wr_fifo_64to256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [63:0]  wr_data = '0;
  logic [255:0] rd_data;
  logic         wr_full, almost_full, rd_empty, almost_empty;
  logic [11:0]  wr_water_level;
  logic [9:0]   rd_water_level;
  logic [25:0]  dut_flags;

  int tests = 0;
  int fails = 0;

  logic [63:0]  mq[$];
  logic [255:0] exp_q[$];
  logic [255:0] last_rd = '0;

  localparam logic [25:0] RstFlags = {12'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  ddr_wr_fifo_64to256 dut (
    .clk            (clk),
    .rst            (rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  assign dut_flags = {wr_water_level, rd_water_level, wr_full, almost_full, rd_empty, almost_empty};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] w(input int k);
    return 64'hFFFF_FFFF_FFFF_FFFF - 64'(k);
  endfunction

  function automatic logic [25:0] model_flags();
    int n;
    n = mq.size();
    return {12'(n), 10'(n / 4), (n == 2048), (n >= 2047), (n < 4), ((n / 4) <= 80)};
  endfunction

  // One clock of stimulus; the model advances at the edge, flags are checked 1 time unit later.
  task automatic step(input logic we, input logic re, input logic [63:0] d, input logic rs);
    bit wr_ok, rd_ok;
    wr_en = we;
    rd_en = re;
    wr_data = d;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      last_rd = '0;
    end else begin
      wr_ok = we && (mq.size() < 2048);
      rd_ok = re && (mq.size() >= 4);
      if (rd_ok) begin
        for (int i = 0; i < 4; i++) last_rd[i*64 +: 64] = mq.pop_front();
      end
      if (re) exp_q.push_back(last_rd);
      if (wr_ok) mq.push_back(d);
    end
    #1;
    check("flags", 256'(dut_flags), 256'(model_flags()));
  endtask

  // Monitor: every non-reset cycle with rd_en presents a word (new or held) on rd_data.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_en === 1'b1 && rst === 1'b0) begin
        #1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_data_unexpected: got %h, required no read", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("rst_rd_data", rd_data, '0);
    check("rst_flags", 256'(dut_flags), 256'(RstFlags));

    for (int k = 0; k < 2049; k++) begin
      step(1'b1, 1'b0, w(k), 1'b0);
      if (k == 2045) check("af_at_2046", {almost_full, wr_full}, 2'b00);
      if (k == 2046) check("af_at_2047", {almost_full, wr_full}, 2'b10);
      if (k == 2047) check("full_at_2048", {wr_full, wr_water_level, rd_water_level},
                           {1'b1, 12'd2048, 10'd512});
    end
    check("write_2049_ignored", {wr_full, wr_water_level}, {1'b1, 12'd2048});

    for (int n = 0; n < 513; n++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      if (n < 512) check("read_word", rd_data, {w(4*n+3), w(4*n+2), w(4*n+1), w(4*n)});
      if (n == 430) check("ae_at_81", {almost_empty, rd_water_level}, {1'b0, 10'd81});
      if (n == 431) check("ae_at_80", {almost_empty, rd_water_level}, {1'b1, 10'd80});
      if (n == 511) check("empty_after_512", {rd_empty, almost_empty, wr_water_level},
                          {1'b1, 1'b1, 12'd0});
    end
    check("read_513_holds", rd_data, {w(2047), w(2046), w(2045), w(2044)});

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
    check("partial_word", {rd_empty, rd_water_level}, {1'b1, 10'd0});
    step(1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
    check("fourth_word", {rd_empty, rd_water_level}, {1'b0, 10'd1});
    step(1'b0, 1'b1, '0, 1'b0);

    step(1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 400; k++) step(1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
    step(1'b1, 1'b1, {$urandom, $urandom}, 1'b0);
    check("simul_rd_wr_397", wr_water_level, 12'd397);

    step(1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 1000; k++) step(1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
    step(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b1);
    check("mid_fill_reset", 256'(dut_flags), 256'(RstFlags));
    check("mid_fill_reset_data", rd_data, '0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, w(k + 100), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("post_reset_word", rd_data, {w(103), w(102), w(101), w(100)});

    // Alternating fill-biased and drain-biased phases to cross full and empty repeatedly.
    for (int i = 0; i < 6000; i++) begin
      bit fill;
      fill = ((i / 1500) % 2) == 0;
      step(($urandom_range(0, 99) < (fill ? 85 : 25)),
           ($urandom_range(0, 99) < (fill ? 10 : 40)),
           {$urandom, $urandom},
           ($urandom_range(0, 1999) == 0));
    end
    step(1'b0, 1'b0, '0, 1'b0);
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
